// File: rtl/age_issue_pkg.sv
// ============================================================================
// Module  : age_issue_pkg
// Purpose : Shared defaults and width helpers for the age-ordered issue queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package age_issue_pkg;

    localparam int DEF_NUM_ENTRIES = 8;
    localparam int DEF_NUM_ENQ     = 2;
    localparam int DEF_NUM_ISS     = 2;
    localparam int DEF_DATA_WIDTH  = 32;

    // Width able to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/age_oldest_select.sv
// ============================================================================
// Module  : age_oldest_select
// Purpose : Picks the 1st..NumIss-th oldest eligible slots from an age matrix.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module age_oldest_select
    import age_issue_pkg::*;
#(
    parameter int NumEntries = DEF_NUM_ENTRIES,
    parameter int NumIss     = DEF_NUM_ISS
) (
    input  logic [NumEntries*NumEntries-1:0] age_i,
    input  logic [NumEntries-1:0]            elig_i,
    output logic [NumIss*NumEntries-1:0]     sel_o
);

    localparam int RankW = cnt_width(NumEntries);

    logic [RankW-1:0] rank [NumEntries];

    // A slot's rank is how many eligible slots are older than it; rank k feeds lane k.
    always_comb begin
        for (int i = 0; i < NumEntries; i++) begin
            rank[i] = '0;
            for (int c = 0; c < NumEntries; c++) begin
                if ((c != i) && elig_i[c] && age_i[c*NumEntries + i]) begin
                    rank[i] = rank[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_o = '0;
        for (int k = 0; k < NumIss; k++) begin
            for (int i = 0; i < NumEntries; i++) begin
                if (elig_i[i] && (rank[i] == RankW'(k))) begin
                    sel_o[k*NumEntries + i] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/age_issue_queue.sv
// ============================================================================
// Module  : age_issue_queue
// Purpose : Multi-lane enqueue / multi-lane oldest-first issue queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module age_issue_queue
    import age_issue_pkg::*;
#(
    parameter int NumEntries = DEF_NUM_ENTRIES,
    parameter int NumEnq     = DEF_NUM_ENQ,
    parameter int NumIss     = DEF_NUM_ISS,
    parameter int DataWidth  = DEF_DATA_WIDTH
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic [NumEnq-1:0]                  enq_valid_i,
    input  logic [NumEnq*DataWidth-1:0]        enq_data_i,
    output logic [NumEnq-1:0]                  enq_ready_o,
    output logic [NumEnq*NumEntries-1:0]       enq_slot_o,
    input  logic [NumEntries-1:0]              slot_rdy_i,
    output logic [NumIss-1:0]                  iss_valid_o,
    output logic [NumIss*DataWidth-1:0]        iss_data_o,
    output logic [NumIss*NumEntries-1:0]       iss_slot_o,
    input  logic [NumIss-1:0]                  iss_ready_i,
    output logic [cnt_width(NumEntries)-1:0]   count_o,
    output logic                               full_o,
    output logic                               empty_o
);

    localparam int CntW  = cnt_width(NumEntries);
    localparam int LaneW = idx_width(NumEnq);

    logic [NumEntries-1:0]            valid_q, valid_d;
    logic [NumEntries*NumEntries-1:0] age_q, age_d;
    logic [DataWidth-1:0]             data_q [NumEntries];
    logic [DataWidth-1:0]             data_d [NumEntries];

    logic [CntW-1:0]                  free_cnt;
    logic [NumEnq*NumEntries-1:0]     alloc;
    logic [NumEnq-1:0]                enq_fire;
    logic [NumEntries-1:0]            new_mask;
    logic [LaneW-1:0]                 new_lane [NumEntries];
    logic [NumIss*NumEntries-1:0]     iss_sel;
    logic [NumEntries-1:0]            iss_clr;
    logic [CntW-1:0]                  count;

    // Allocation looks only at registered valid, so slots issued this cycle stay unavailable.
    always_comb begin
        free_cnt = '0;
        alloc    = '0;
        for (int i = 0; i < NumEntries; i++) begin
            if (!valid_q[i]) begin
                for (int j = 0; j < NumEnq; j++) begin
                    if (free_cnt == CntW'(j)) begin
                        alloc[j*NumEntries + i] = 1'b1;
                    end
                end
                free_cnt = free_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar j = 0; j < NumEnq; j++) begin : g_enq_rdy
            assign enq_ready_o[j] = (free_cnt > CntW'(j));
        end
    endgenerate

    assign enq_slot_o = alloc;
    assign enq_fire   = enq_valid_i & enq_ready_o;

    always_comb begin
        new_mask = '0;
        data_d   = data_q;
        for (int i = 0; i < NumEntries; i++) begin
            new_lane[i] = '0;
        end
        for (int j = 0; j < NumEnq; j++) begin
            for (int i = 0; i < NumEntries; i++) begin
                if (enq_fire[j] && alloc[j*NumEntries + i]) begin
                    new_mask[i] = 1'b1;
                    new_lane[i] = LaneW'(j);
                    data_d[i]   = enq_data_i[j*DataWidth +: DataWidth];
                end
            end
        end
    end

    age_oldest_select #(
        .NumEntries (NumEntries),
        .NumIss     (NumIss)
    ) u_select (
        .age_i  (age_q),
        .elig_i (valid_q & slot_rdy_i),
        .sel_o  (iss_sel)
    );

    assign iss_slot_o = iss_sel;

    always_comb begin
        iss_valid_o = '0;
        iss_data_o  = '0;
        iss_clr     = '0;
        for (int k = 0; k < NumIss; k++) begin
            iss_valid_o[k] = |iss_sel[k*NumEntries +: NumEntries];
            for (int i = 0; i < NumEntries; i++) begin
                if (iss_sel[k*NumEntries + i]) begin
                    iss_data_o[k*DataWidth +: DataWidth] =
                        iss_data_o[k*DataWidth +: DataWidth] | data_q[i];
                    if (iss_ready_i[k]) begin
                        iss_clr[i] = 1'b1;
                    end
                end
            end
        end
    end

    // New rows say "older than nobody except later same-cycle lanes"; new columns mark every survivor older.
    always_comb begin
        age_d = age_q;
        for (int r = 0; r < NumEntries; r++) begin
            for (int c = 0; c < NumEntries; c++) begin
                if (r == c) begin
                    age_d[r*NumEntries + c] = 1'b0;
                end else if (new_mask[r] && new_mask[c]) begin
                    age_d[r*NumEntries + c] = (new_lane[r] < new_lane[c]);
                end else if (new_mask[r]) begin
                    age_d[r*NumEntries + c] = 1'b0;
                end else if (new_mask[c]) begin
                    age_d[r*NumEntries + c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (flush_i) begin
            valid_d = '0;
        end else begin
            valid_d = (valid_q & ~iss_clr) | new_mask;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NumEntries; i++) begin
            count = count + CntW'(valid_q[i]);
        end
    end

    assign count_o = count;
    assign full_o  = (count == CntW'(NumEntries));
    assign empty_o = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_age_issue_queue.sv
// ============================================================================
// Module  : tb_age_issue_queue
// Purpose : Directed self-checking bench for age_issue_queue (default params).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_age_issue_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [1:0]  enq_valid_i;
    logic [63:0] enq_data_i;
    logic [1:0]  enq_ready_o;
    logic [15:0] enq_slot_o;
    logic [7:0]  slot_rdy_i;
    logic [1:0]  iss_valid_o;
    logic [63:0] iss_data_o;
    logic [15:0] iss_slot_o;
    logic [1:0]  iss_ready_i;
    logic [3:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    age_issue_queue dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_data_i  (enq_data_i),
        .enq_ready_o (enq_ready_o),
        .enq_slot_o  (enq_slot_o),
        .slot_rdy_i  (slot_rdy_i),
        .iss_valid_o (iss_valid_o),
        .iss_data_o  (iss_data_o),
        .iss_slot_o  (iss_slot_o),
        .iss_ready_i (iss_ready_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_l0 [4] = '{32'h101, 32'h103, 32'h105, 32'h107};
    logic [31:0] exp_l1 [4] = '{32'h102, 32'h104, 32'h106, 32'hDDDD};

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 2'b00;
        enq_data_i  = '0;
        slot_rdy_i  = 8'h00;
        iss_ready_i = 2'b00;
        #3;
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_empty", 64'(empty_o), 64'd1);
        check_eq("rst_full", 64'(full_o), 64'd0);
        check_eq("rst_iss_valid", 64'(iss_valid_o), 64'd0);
        check_eq("rst_enq_ready", 64'(enq_ready_o), 64'b11);
        tick();
        tick();
        rst_ni = 1'b1;

        // Two-lane enqueue then dual issue
        enq_valid_i = 2'b11;
        enq_data_i  = {32'hBBBB0002, 32'hAAAA0001};
        slot_rdy_i  = 8'hFF;
        settle();
        check_eq("enq_slot_first", 64'(enq_slot_o), 64'h0201);
        check_eq("no_bypass", 64'(iss_valid_o), 64'd0);
        tick();
        enq_valid_i = 2'b00;
        settle();
        check_eq("ab_count", 64'(count_o), 64'd2);
        check_eq("ab_iss_valid", 64'(iss_valid_o), 64'b11);
        check_eq("ab_iss_data", iss_data_o, 64'hBBBB0002_AAAA0001);
        check_eq("ab_iss_slot", 64'(iss_slot_o), 64'h0201);
        iss_ready_i = 2'b11;
        tick();
        iss_ready_i = 2'b00;
        settle();
        check_eq("ab_drained", 64'(count_o), 64'd0);

        // Fill to full
        for (int c = 0; c < 4; c++) begin
            enq_valid_i = 2'b11;
            enq_data_i  = {32'(32'h100 + 2*c + 1), 32'(32'h100 + 2*c)};
            tick();
        end
        enq_valid_i = 2'b00;
        settle();
        check_eq("fill_full", 64'(full_o), 64'd1);
        check_eq("fill_count", 64'(count_o), 64'd8);
        check_eq("fill_enq_ready", 64'(enq_ready_o), 64'b00);
        check_eq("fill_oldest", iss_data_o, 64'h00000101_00000100);
        iss_ready_i = 2'b01;
        settle();
        check_eq("freed_not_same_cycle", 64'(enq_ready_o), 64'b00);
        tick();
        iss_ready_i = 2'b00;
        settle();
        check_eq("freed_next_cycle", 64'(enq_ready_o), 64'b01);
        check_eq("after_iss_count", 64'(count_o), 64'd7);
        check_eq("after_iss_full", 64'(full_o), 64'd0);
        check_eq("realloc_slot", 64'(enq_slot_o), 64'h0001);

        // D into slot 0 must be youngest
        enq_valid_i = 2'b01;
        enq_data_i  = {32'h0, 32'hDDDD};
        tick();
        enq_valid_i = 2'b00;
        slot_rdy_i  = 8'h03;
        settle();
        check_eq("d_count", 64'(count_o), 64'd8);
        check_eq("d_youngest_data", iss_data_o, 64'h0000DDDD_00000101);
        check_eq("d_youngest_slot", 64'(iss_slot_o), 64'h0102);
        slot_rdy_i  = 8'hFF;
        iss_ready_i = 2'b11;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_eq($sformatf("drain_l0_%0d", c), 64'(iss_data_o[31:0]), 64'(exp_l0[c]));
            check_eq($sformatf("drain_l1_%0d", c), 64'(iss_data_o[63:32]), 64'(exp_l1[c]));
            tick();
        end
        iss_ready_i = 2'b00;
        settle();
        check_eq("drain_empty", 64'(empty_o), 64'd1);

        // Partial wakeup: A oldest, only A and C ready
        enq_valid_i = 2'b11;
        enq_data_i  = {32'hB, 32'hA};
        tick();
        enq_valid_i = 2'b01;
        enq_data_i  = {32'h0, 32'hC};
        tick();
        enq_valid_i = 2'b00;
        slot_rdy_i  = 8'b0000_0101;
        settle();
        check_eq("wake_data", iss_data_o, 64'h0000000C_0000000A);
        check_eq("wake_slot", 64'(iss_slot_o), 64'h0401);
        iss_ready_i = 2'b10;
        tick();
        iss_ready_i = 2'b00;
        slot_rdy_i  = 8'hFF;
        settle();
        check_eq("wake_count", 64'(count_o), 64'd2);
        check_eq("a_still_oldest", iss_data_o, 64'h0000000B_0000000A);

        // Flush beats simultaneous enqueue and issue
        flush_i     = 1'b1;
        enq_valid_i = 2'b11;
        enq_data_i  = {32'hEE, 32'hFF};
        iss_ready_i = 2'b11;
        settle();
        check_eq("flush_enq_ready_ungated", 64'(enq_ready_o), 64'b11);
        check_eq("flush_iss_valid_ungated", 64'(iss_valid_o), 64'b11);
        tick();
        flush_i     = 1'b0;
        enq_valid_i = 2'b00;
        iss_ready_i = 2'b00;
        settle();
        check_eq("flush_count", 64'(count_o), 64'd0);
        check_eq("flush_empty", 64'(empty_o), 64'd1);
        check_eq("flush_iss_valid", 64'(iss_valid_o), 64'd0);
        check_eq("flush_iss_data_zero", iss_data_o, 64'd0);
        check_eq("flush_iss_slot_zero", 64'(iss_slot_o), 64'd0);

        // Asynchronous reset mid-operation
        enq_valid_i = 2'b11;
        enq_data_i  = {32'h22, 32'h11};
        tick();
        enq_valid_i = 2'b00;
        settle();
        check_eq("pre_reset_count", 64'(count_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst_count", 64'(count_o), 64'd0);
        check_eq("async_rst_iss_valid", 64'(iss_valid_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        settle();
        check_eq("post_rst_empty", 64'(empty_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
